uart_bus_monitor: RTL and testbench
===================================

# uart_bus_monitor

UART-driven debug master for the external memory bus. It parses byte commands arriving from `uart_rx` and issues single or burst word transactions on one requester port of the `IO_SYNC` arbitrator, in the same slot the execution engine otherwise uses. Results and status go back through `uart_tx`. It sits in the `CPU` top, between the UART pair and the arbitrator, and gives bring-up access to external RAM/IO without the decoder.

## Interface
Parameters:
- `TIMEOUT`, 1600000: maximum inter-byte gap in `CLK` cycles (100 ms at 16 MHz) before a partial command is dropped.
- `TW`, 21: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- `CLK`  input  1  system clock, 16 MHz. One clock domain; everything updates on posedge `CLK`.
- `RST`  input  1  synchronous, active-high reset.
- `rx_data`  input  8  received byte; valid while `rx_new` is high.
- `rx_new`  input  1  one-cycle strobe from `uart_rx`.
- `tx_rdy`  input  1  `uart_tx` idle.
- `tx_new`  output  1  one-cycle strobe to `uart_tx`.
- `tx_char`  output  8  byte to send; held stable from the strobe until the next strobe.
- `req`  output  1  bus request to the arbitrator.
- `ack`  input  1  one-cycle completion strobe from the arbitrator.
- `rw`  output  1  1 = read, 0 = write.
- `adr`  output  20  word address.
- `dtw`  output  16  write data.
- `dtr`  input  16  read data; valid in the `ack` cycle.
- `busy`  output  1  high in every state except IDLE; drives the LED.
- `overrun`  output  1  one-cycle pulse when a byte arrives while it cannot be accepted.

## Operation
Command bytes (all multi-byte fields are sent MSB first):
- `0x52` 'R' A2 A1 A0: read one word. Response is D[15:8], D[7:0].
- `0x57` 'W' A2 A1 A0 Dh Dl: write one word. Response is `0x06`.
- `0x42` 'B' A2 A1 A0 N: read N+1 words (1..256) at adr, adr+1, and so on. Each word is returned as two bytes, high byte first.
- Any other first byte: response `0x15` (NAK), then return to IDLE.

Field rules:
- `adr` = {A2[3:0], A1, A0}. A2[7:4] is ignored.
- The burst address increments modulo 2^20, so 0xFFFFF is followed by 0x00000.

States:
- IDLE → CMD captured → A2 → A1 → A0.
- From A0: 'W' goes to DH → DL → BUS; 'B' goes to CNT → BUS; 'R' goes directly to BUS.
- BUS → TXH → TXL → (burst count remaining ? BUS : IDLE). For a write, BUS → TXACK → IDLE.
- NAK: CMD → TXNAK → IDLE.

Parse states (A2..CNT):
- Each `rx_new` advances one state and reloads the timeout counter to 0.
- If the counter reaches `TIMEOUT` with no byte, return to IDLE silently: no bus cycle, no TX.

BUS, TX*, and any other non-parse state:
- An `rx_new` here does not change state; the byte is dropped and `overrun` pulses.
- An `rx_new` in IDLE is never an overrun.

## Timing
Reset values:
- `req`=0, `rw`=1, `adr`=0, `dtw`=0.
- `tx_new`=0, `tx_char`=0, `busy`=0, `overrun`=0.
- State = IDLE, timeout counter = 0, burst count = 0.

Bus handshake:
- Enter BUS: `req` rises the next edge, with `rw`/`adr`/`dtw` already valid on that edge.
- `req`, `rw`, `adr` and `dtw` are held constant until `ack`=1 is sampled.
- On the `ack` edge: latch `dtr` into a 16-bit hold register, drop `req` on that same edge, and increment `adr` if the burst continues.
- `req` is never high on two consecutive transactions without at least one low cycle between them.
- `ack` sampled while `req`=0 is ignored.

TX handshake:
- In a TX state, wait for `tx_rdy`=1, then pulse `tx_new` for one cycle with `tx_char` set.
- Then wait until `tx_rdy` has been observed low and then high again before the next pulse or before leaving the TX sequence.

Latency and timeout boundary:
- Minimum latency from the last command byte's `rx_new` to `req`=1 is 1 cycle.
- Timeout is inclusive: a byte arriving in the exact cycle the counter equals `TIMEOUT` is accepted.

Reset mid-operation:
- `RST` overrides all; outputs reach their reset values on the next edge, `req` included.
- A late `ack` after reset is ignored.

Simultaneous `ack` and `rx_new` in BUS: the `ack` is processed and the byte is dropped with an `overrun` pulse.

## Test plan
- Read: RX 52 00 12 34; bench acks with `dtr`=0xBEEF → exactly one `req` with `adr`=0x01234, `rw`=1; TX BE, EF; `busy` returns to 0.
- Write: RX 57 FF AB CD 12 34 → `adr`=0xFABCD (A2 high nibble ignored), `rw`=0, `dtw`=0x1234; TX 06.
- Burst wrap: RX 42 0F FF FF 01; acks return 0x1111, 0x2222 → `adr` 0xFFFFF then 0x00000, `req` low ≥1 cycle between them; TX 11 11 22 22.
- Unknown byte plus overrun: RX 58 → TX 15. Then RX 52 00 00 01 and, while waiting on `ack`, inject RX 33 → one `overrun` pulse; the read still completes normally.
- Timeout: RX 52 00, then idle `TIMEOUT`+1 cycles → no `req`, no TX, `busy`=0. A fresh RX 52 00 00 05 → `adr`=0x00005.
- Reset in BUS: assert `RST` for 1 cycle while `req`=1 → `req`=0, `busy`=0 next edge; a following `ack` causes no TX.

Source files
------------

// File: rtl/uart_bus_monitor.sv
`default_nettype none
//============================================================================
// Module   : uart_bus_monitor
// Purpose  : UART-driven debug master for the external memory bus. Parses
//            byte commands from uart_rx, runs single/burst word transactions
//            on one arbitrator requester port and reports results and
//            status back through uart_tx.
// Ports    : CLK, RST          - clock, synchronous active-high reset
//            rx_data, rx_new   - received byte and its one-cycle strobe
//            tx_rdy            - uart_tx idle
//            tx_new, tx_char   - transmit strobe and byte
//            req, ack, rw, adr,
//            dtw, dtr          - arbitrator requester handshake
//            busy              - high whenever not idle (LED)
//            overrun           - pulse when a byte had to be dropped
// Commands : 'R' A2 A1 A0        read one word  -> Dh Dl
//            'W' A2 A1 A0 Dh Dl  write one word -> 0x06
//            'B' A2 A1 A0 N      read N+1 words -> Dh Dl per word
//            anything else       -> 0x15
// Revision : 1.0  initial release
//============================================================================
module uart_bus_monitor #(
    parameter int TIMEOUT = 1600000,
    parameter int TW      = 21
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  rx_data,
    input  logic        rx_new,
    input  logic        tx_rdy,
    output logic        tx_new,
    output logic [7:0]  tx_char,
    output logic        req,
    input  logic        ack,
    output logic        rw,
    output logic [19:0] adr,
    output logic [15:0] dtw,
    input  logic [15:0] dtr,
    output logic        busy,
    output logic        overrun
);

    localparam logic [7:0]    c_CMD_READ  = 8'h52;
    localparam logic [7:0]    c_CMD_WRITE = 8'h57;
    localparam logic [7:0]    c_CMD_BURST = 8'h42;
    localparam logic [7:0]    c_RSP_ACK   = 8'h06;
    localparam logic [7:0]    c_RSP_NAK   = 8'h15;
    localparam logic [TW-1:0] c_TIMEOUT   = TW'(TIMEOUT);

    // The command byte is decoded in IDLE as it is captured, so the
    // following address byte may arrive back-to-back.
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_A2    = 4'd1,
        S_A1    = 4'd2,
        S_A0    = 4'd3,
        S_DH    = 4'd4,
        S_DL    = 4'd5,
        S_CNT   = 4'd6,
        S_BUS   = 4'd7,
        S_TXH   = 4'd8,
        S_TXL   = 4'd9,
        S_TXACK = 4'd10,
        S_TXNAK = 4'd11
    } state_t;

    // Per-byte transmit handshake: send on tx_rdy, then see tx_rdy go low
    // and back high before the byte counts as done.
    typedef enum logic [1:0] {
        TXP_SEND      = 2'd0,
        TXP_WAIT_LOW  = 2'd1,
        TXP_WAIT_HIGH = 2'd2
    } txph_t;

    state_t        r_state;
    state_t        w_state_next;
    txph_t         r_txph;
    txph_t         w_txph_next;

    logic [7:0]    r_cmd;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_cnt;
    logic          r_more;
    logic [15:0]   r_hold;
    logic          r_req;
    logic          r_rw;
    logic [19:0]   r_adr;
    logic [15:0]   r_dtw;
    logic          r_tx_new;
    logic [7:0]    r_tx_char;
    logic          r_busy;
    logic          r_overrun;

    logic          w_parse;
    logic          w_tx_state;
    logic          w_timeout;
    logic          w_ack;
    logic          w_send;
    logic          w_tx_done;
    logic [7:0]    w_tx_byte;
    logic          w_overrun;
    logic          w_req_set;

    //------------------------------------------------------------------
    // State registers
    //------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_txph  <= TXP_SEND;
        end else begin
            r_state <= w_state_next;
            r_txph  <= w_txph_next;
        end
    end

    //------------------------------------------------------------------
    // Next-state and control decode
    //------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_txph_next  = r_txph;
        w_send       = 1'b0;
        w_tx_done    = 1'b0;
        w_tx_byte    = 8'h00;

        w_parse = (r_state == S_A2) || (r_state == S_A1) || (r_state == S_A0) ||
                  (r_state == S_DH) || (r_state == S_DL) || (r_state == S_CNT);
        w_tx_state = (r_state == S_TXH) || (r_state == S_TXL) ||
                     (r_state == S_TXACK) || (r_state == S_TXNAK);
        // Inclusive boundary: a byte in the cycle the counter equals
        // TIMEOUT still wins over the timeout.
        w_timeout = w_parse && !rx_new && (r_tmo == c_TIMEOUT);
        // ack is only meaningful while a request is outstanding.
        w_ack     = r_req && ack;
        // Bytes are only accepted in IDLE and the parse states.
        w_overrun = rx_new && (r_state != S_IDLE) && !w_parse;

        case (r_state)
            S_TXH:   w_tx_byte = r_hold[15:8];
            S_TXL:   w_tx_byte = r_hold[7:0];
            S_TXACK: w_tx_byte = c_RSP_ACK;
            S_TXNAK: w_tx_byte = c_RSP_NAK;
            default: w_tx_byte = 8'h00;
        endcase

        if (w_tx_state) begin
            case (r_txph)
                TXP_SEND: begin
                    if (tx_rdy) begin
                        w_send      = 1'b1;
                        w_txph_next = TXP_WAIT_LOW;
                    end
                end
                TXP_WAIT_LOW: begin
                    if (!tx_rdy) begin
                        w_txph_next = TXP_WAIT_HIGH;
                    end
                end
                TXP_WAIT_HIGH: begin
                    if (tx_rdy) begin
                        w_tx_done   = 1'b1;
                        w_txph_next = TXP_SEND;
                    end
                end
                default: w_txph_next = TXP_SEND;
            endcase
        end

        case (r_state)
            S_IDLE: begin
                if (rx_new) begin
                    if ((rx_data == c_CMD_READ) || (rx_data == c_CMD_WRITE) ||
                        (rx_data == c_CMD_BURST)) begin
                        w_state_next = S_A2;
                    end else begin
                        w_state_next = S_TXNAK;
                    end
                end
            end
            S_A2:  if (rx_new) w_state_next = S_A1;
            S_A1:  if (rx_new) w_state_next = S_A0;
            S_A0: begin
                if (rx_new) begin
                    if (r_cmd == c_CMD_WRITE) begin
                        w_state_next = S_DH;
                    end else if (r_cmd == c_CMD_BURST) begin
                        w_state_next = S_CNT;
                    end else begin
                        w_state_next = S_BUS;
                    end
                end
            end
            S_DH:  if (rx_new) w_state_next = S_DL;
            S_DL:  if (rx_new) w_state_next = S_BUS;
            S_CNT: if (rx_new) w_state_next = S_BUS;
            S_BUS: begin
                if (w_ack) begin
                    w_state_next = r_rw ? S_TXH : S_TXACK;
                end
            end
            S_TXH: if (w_tx_done) w_state_next = S_TXL;
            S_TXL: if (w_tx_done) w_state_next = r_more ? S_BUS : S_IDLE;
            S_TXACK, S_TXNAK: if (w_tx_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase

        if (w_timeout) begin
            w_state_next = S_IDLE;
        end

        // req is raised on the very edge that enters BUS, which gives the
        // one-cycle latency from the final command byte.
        w_req_set = (w_state_next == S_BUS) && (r_state != S_BUS);
    end

    //------------------------------------------------------------------
    // Datapath and registered outputs
    //------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cmd     <= 8'h00;
            r_tmo     <= '0;
            r_cnt     <= 8'h00;
            r_more    <= 1'b0;
            r_hold    <= 16'h0000;
            r_req     <= 1'b0;
            r_rw      <= 1'b1;
            r_adr     <= 20'h00000;
            r_dtw     <= 16'h0000;
            r_tx_new  <= 1'b0;
            r_tx_char <= 8'h00;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_tx_new  <= w_send;
            if (w_send) begin
                r_tx_char <= w_tx_byte;
            end
            r_overrun <= w_overrun;
            r_busy    <= (w_state_next != S_IDLE);

            // Counter runs only while waiting for a parse byte; any byte,
            // expiry or leaving the parse states puts it back to zero.
            if (w_parse && !rx_new && !w_timeout) begin
                r_tmo <= r_tmo + TW'(1);
            end else begin
                r_tmo <= '0;
            end

            if (rx_new) begin
                case (r_state)
                    S_IDLE: begin
                        r_cmd <= rx_data;
                        r_rw  <= (rx_data != c_CMD_WRITE);
                    end
                    S_A2:  r_adr[19:16] <= rx_data[3:0];
                    S_A1:  r_adr[15:8]  <= rx_data;
                    S_A0:  r_adr[7:0]   <= rx_data;
                    S_DH:  r_dtw[15:8]  <= rx_data;
                    S_DL:  r_dtw[7:0]   <= rx_data;
                    S_CNT: r_cnt        <= rx_data;
                    default: ;
                endcase
            end

            if (w_req_set) begin
                r_req <= 1'b1;
            end else if (w_ack) begin
                r_req <= 1'b0;
            end

            if (w_ack) begin
                r_hold <= dtr;
                // A burst continues while words remain; the address is
                // advanced here so it is already stable for the next req.
                if ((r_cmd == c_CMD_BURST) && (r_cnt != 8'h00)) begin
                    r_more <= 1'b1;
                    r_cnt  <= r_cnt - 8'd1;
                    r_adr  <= r_adr + 20'd1;
                end else begin
                    r_more <= 1'b0;
                end
            end
        end
    end

    assign tx_new  = r_tx_new;
    assign tx_char = r_tx_char;
    assign req     = r_req;
    assign rw      = r_rw;
    assign adr     = r_adr;
    assign dtw     = r_dtw;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_monitor.sv
`default_nettype none
//============================================================================
// Module   : tb_uart_bus_monitor
// Purpose  : Self-checking bench for uart_bus_monitor. Commands are turned
//            into expected bus transactions and TX bytes by a command-level
//            model; independent monitors pop and compare as the DUT acts.
// Revision : 1.0  initial release
//============================================================================
module tb_uart_bus_monitor;

    localparam int TMO  = 40;
    localparam int TWID = 6;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_new = 1'b0;
    logic        tx_rdy = 1'b1;
    logic        ack = 1'b0;
    logic [15:0] dtr = 16'h0000;
    logic        tx_new;
    logic [7:0]  tx_char;
    logic        req;
    logic        rw;
    logic [19:0] adr;
    logic [15:0] dtw;
    logic        busy;
    logic        overrun;

    uart_bus_monitor #(.TIMEOUT(TMO), .TW(TWID)) dut (
        .CLK(CLK), .RST(RST),
        .rx_data(rx_data), .rx_new(rx_new),
        .tx_rdy(tx_rdy), .tx_new(tx_new), .tx_char(tx_char),
        .req(req), .ack(ack), .rw(rw), .adr(adr), .dtw(dtw), .dtr(dtr),
        .busy(busy), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rw;
        logic [19:0] adr;
        logic [15:0] dtw;
    } bus_t;
    typedef logic [7:0] byte_q_t[$];

    int n_chk  = 0;
    int n_pass = 0;
    bus_t       bus_q[$];
    logic [7:0] tx_q[$];
    logic [15:0] ram [int];   // responder-side memory, written by the DUT
    logic [15:0] mdl [int];   // model-side memory, written by the model
    int  tx_seen  = 0;
    int  ovr_seen = 0;
    int  ovr_exp  = 0;
    bit  auto_ack = 1'b1;
    bit  pend_ack = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] init_word(input int a);
        return 16'((a * 40503) ^ (a >>> 5) ^ 16'h3C5A);
    endfunction
    function automatic logic [15:0] ram_rd(input int a);
        return ram.exists(a) ? ram[a] : init_word(a);
    endfunction
    function automatic logic [15:0] mdl_rd(input int a);
        return mdl.exists(a) ? mdl[a] : init_word(a);
    endfunction

    // Command-level reference: bytes in, expected bus ops and TX bytes out.
    task automatic expect_cmd(input byte_q_t b);
        bus_t        e;
        int          a;
        int          n;
        logic [15:0] d;
        a = 0;
        if (b.size() >= 4) a = {b[1][3:0], b[2], b[3]};
        case (b[0])
            8'h52: begin
                e.rw = 1'b1; e.adr = 20'(a); e.dtw = 16'h0000;
                bus_q.push_back(e);
                d = mdl_rd(a);
                tx_q.push_back(d[15:8]); tx_q.push_back(d[7:0]);
            end
            8'h57: begin
                d = {b[4], b[5]};
                e.rw = 1'b0; e.adr = 20'(a); e.dtw = d;
                bus_q.push_back(e);
                mdl[a] = d;
                tx_q.push_back(8'h06);
            end
            8'h42: begin
                n = int'(b[4]);
                for (int i = 0; i <= n; i++) begin
                    e.rw = 1'b1; e.adr = 20'((a + i) & 32'hFFFFF); e.dtw = 16'h0000;
                    bus_q.push_back(e);
                    d = mdl_rd(int'(e.adr));
                    tx_q.push_back(d[15:8]); tx_q.push_back(d[7:0]);
                end
            end
            default: tx_q.push_back(8'h15);
        endcase
    endtask

    task automatic mk(input int n, input logic [47:0] v, output byte_q_t q);
        q.delete();
        for (int i = n - 1; i >= 0; i--) q.push_back(v[8*i +: 8]);
    endtask

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic send_one(input logic [7:0] b);
        rx_data = b;
        rx_new  = 1'b1;
        @(negedge CLK);
        rx_new  = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t b, input int maxgap);
        foreach (b[i]) begin
            send_one(b[i]);
            repeat ($urandom_range(0, maxgap)) @(negedge CLK);
        end
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((busy || bus_q.size() != 0 || tx_q.size() != 0) && t < 4000) begin
            @(negedge CLK);
            t++;
        end
        chk({nm, "_complete"}, {busy, 15'(bus_q.size()), 16'(tx_q.size())}, 32'h0);
    endtask

    task automatic wait_req(input string nm);
        int t;
        t = 0;
        while (!req && t < 200) begin
            @(negedge CLK);
            t++;
        end
        chk(nm, {31'h0, req}, 32'h1);
    endtask

    task automatic run_cmd(input string nm, input byte_q_t b);
        expect_cmd(b);
        send_bytes(b, 3);
        wait_idle(nm);
    endtask

    // Bus monitor: compares each new request and checks it is held stable.
    initial begin : bus_monitor
        bus_t e;
        logic [36:0] snap;
        bit req_q, held_bad;
        req_q = 1'b0; held_bad = 1'b0; snap = '0;
        forever begin
            @(negedge CLK);
            if (req && !req_q) begin
                if (bus_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL bus_unexpected: got req adr=%0h rw=%0b expected none", adr, rw);
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_rw", {31'h0, rw}, {31'h0, e.rw});
                    chk("bus_adr", {12'h0, adr}, {12'h0, e.adr});
                    if (!e.rw) chk("bus_dtw", {16'h0, dtw}, {16'h0, e.dtw});
                end
                snap = {rw, adr, dtw};
                held_bad = 1'b0;
            end else if (req && req_q) begin
                if ({rw, adr, dtw} !== snap) held_bad = 1'b1;
            end
            if (!req && req_q && !RST) chk("bus_hold", {31'h0, held_bad}, 32'h0);
            req_q = req;
        end
    end

    // Arbitrator responder with a word memory and random ack latency.
    initial begin : bus_responder
        int  wdly;
        bit  acked;
        wdly = 0; acked = 1'b0;
        forever begin
            @(negedge CLK);
            if (acked) begin
                acked = 1'b0;
                chk("req_drop_after_ack", {31'h0, req}, 32'h0);
            end
            ack = 1'b0;
            dtr = 16'($urandom);
            if (pend_ack) begin
                ack = 1'b1;
                pend_ack = 1'b0;
            end else if (auto_ack && req && !RST) begin
                if (wdly == 0) begin
                    ack = 1'b1;
                    if (rw) dtr = ram_rd(int'(adr));
                    else    ram[int'(adr)] = dtw;
                    acked = 1'b1;
                    wdly = $urandom_range(0, 3);
                end else begin
                    wdly--;
                end
            end
        end
    end

    // uart_tx model and TX byte checker.
    initial begin : tx_monitor
        int rdy_cnt;
        logic [7:0] e;
        rdy_cnt = 0;
        forever begin
            @(negedge CLK);
            if (tx_new) begin
                tx_seen++;
                chk("tx_strobe_when_ready", {31'h0, tx_rdy}, 32'h1);
                if (tx_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL tx_unexpected: got %0h expected none", tx_char);
                end else begin
                    e = tx_q.pop_front();
                    chk("tx_char", {24'h0, tx_char}, {24'h0, e});
                end
                tx_rdy  = 1'b0;
                rdy_cnt = $urandom_range(1, 6);
            end else if (rdy_cnt > 0) begin
                rdy_cnt--;
                if (rdy_cnt == 0) tx_rdy = 1'b1;
            end
        end
    end

    initial begin : ovr_monitor
        forever begin
            @(negedge CLK);
            if (overrun) ovr_seen++;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        byte_q_t cmd;
        int      sel;
        int      tx_before;
        logic [7:0] b0;
        logic [19:0] ra;

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_req_rw", {30'h0, req, rw}, 32'h1);
        chk("rst_adr", {12'h0, adr}, 32'h0);
        chk("rst_dtw", {16'h0, dtw}, 32'h0);
        chk("rst_tx", {23'h0, tx_new, tx_char}, 32'h0);
        chk("rst_busy_ovr", {30'h0, busy, overrun}, 32'h0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Single read
        ram[32'h01234] = 16'hBEEF; mdl[32'h01234] = 16'hBEEF;
        mk(4, 48'h52_00_12_34, cmd);
        run_cmd("read", cmd);

        // Write, A2 high nibble ignored
        mk(6, 48'h57_FF_AB_CD_12_34, cmd);
        run_cmd("write", cmd);
        chk("write_mem", {16'h0, ram_rd(32'hFABCD)}, 32'h1234);

        // Burst across the top of the address space
        ram[32'hFFFFF] = 16'h1111; mdl[32'hFFFFF] = 16'h1111;
        ram[32'h00000] = 16'h2222; mdl[32'h00000] = 16'h2222;
        mk(5, 48'h42_0F_FF_FF_01, cmd);
        run_cmd("burst_wrap", cmd);

        // Unknown command
        mk(1, 48'h58, cmd);
        run_cmd("nak", cmd);

        // Byte arriving while the bus cycle is outstanding
        auto_ack = 1'b0;
        mk(4, 48'h52_00_00_01, cmd);
        expect_cmd(cmd);
        send_bytes(cmd, 2);
        wait_req("ovr_req_up");
        send_one(8'h33);
        ovr_exp++;
        repeat (3) @(negedge CLK);
        auto_ack = 1'b1;
        wait_idle("overrun_read");
        chk("overrun_count", 32'(ovr_seen), 32'(ovr_exp));

        // Timeout drops a partial command silently
        tx_before = tx_seen;
        send_one(8'h52);
        send_one(8'h00);
        repeat (TMO + 1) @(negedge CLK);
        chk("timeout_busy", {31'h0, busy}, 32'h0);
        chk("timeout_no_tx", 32'(tx_seen), 32'(tx_before));
        mk(4, 48'h52_00_00_05, cmd);
        run_cmd("after_timeout", cmd);

        // Byte exactly at the timeout boundary is still accepted
        mk(4, 48'h52_03_21_43, cmd);
        expect_cmd(cmd);
        send_one(8'h52);
        send_one(8'h03);
        repeat (TMO) @(negedge CLK);
        chk("boundary_busy", {31'h0, busy}, 32'h1);
        send_one(8'h21);
        send_one(8'h43);
        wait_idle("boundary");

        // Reset while the request is outstanding
        auto_ack = 1'b0;
        mk(4, 48'h52_0A_BC_DE, cmd);
        expect_cmd(cmd);
        send_bytes(cmd, 2);
        wait_req("rst_req_up");
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_bus_req_busy", {30'h0, req, busy}, 32'h0);
        chk("rst_bus_adr_rw", {11'h0, adr, rw}, 32'h1);
        tx_q.delete();
        tx_before = tx_seen;
        pend_ack = 1'b1;
        repeat (20) @(negedge CLK);
        chk("late_ack_no_tx", 32'(tx_seen), 32'(tx_before));
        chk("late_ack_idle", {30'h0, req, busy}, 32'h0);
        auto_ack = 1'b1;

        // Randomized command mix
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            ra  = ($urandom_range(0, 3) == 0) ? 20'hFFFFF - 20'($urandom_range(0, 3))
                                              : 20'($urandom);
            b0  = 8'($urandom);
            cmd.delete();
            if (sel <= 3) begin
                cmd.push_back(8'h52);
            end else if (sel <= 6) begin
                cmd.push_back(8'h57);
            end else if (sel <= 8) begin
                cmd.push_back(8'h42);
            end else begin
                while (b0 == 8'h52 || b0 == 8'h57 || b0 == 8'h42) b0 = 8'($urandom);
                cmd.push_back(b0);
            end
            if (sel <= 8) begin
                cmd.push_back({4'($urandom), ra[19:16]});
                cmd.push_back(ra[15:8]);
                cmd.push_back(ra[7:0]);
            end
            if (sel >= 4 && sel <= 6) begin
                cmd.push_back(8'($urandom));
                cmd.push_back(8'($urandom));
            end
            if (sel == 7 || sel == 8) cmd.push_back(8'($urandom_range(0, 5)));
            run_cmd("random", cmd);
        end
        chk("overrun_total", 32'(ovr_seen), 32'(ovr_exp));

        repeat (5) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
